// File: rtl/pipeline_stall_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_stall_ctrl
//
// Central stall/flush controller for a 5-stage in-order pipeline. Merges the
// instruction-bus wait, data-bus wait, load-use hazard and a multi-cycle
// mul/div sequencer into a monotonic per-stage stall vector. It also delivers
// exception/eret flushes, holding back any flush that arrives while the data
// bus is waiting.
//
// Parameters:
//   MULDIV_CYCLES  number of BUSY cycles of a mul/div op (2..255)
//   WDOG_WIDTH     width of the optional stall-hang watchdog counter
//
// Ports:
//   clk              clock, all state updates on rising edge
//   rst              asynchronous active-high reset
//   if_mem_wait      instruction bus not ready
//   mem_mem_wait     data bus not ready
//   id_load_use      load-use hazard detected in ID
//   ex_muldiv_start  EX holds a mul/div starting this cycle
//   flush            exception/eret flush request
//   stall[4:0]       per-stage stall (0=IF .. 4=WB), combinational
//   flush_out        flush delivered to the pipeline
//   muldiv_busy      mul/div sequencer in BUSY
//   muldiv_done      mul/div sequencer in DONE (result valid)
//   watchdog_trip    sticky stall-hang flag
//
// Build option:
//   STALL_WATCHDOG_EN  when defined, a WDOG_WIDTH-bit counter tracks
//                      consecutive IF-stall cycles and trips watchdog_trip
//                      on saturation. When undefined, watchdog_trip is 0.
// ----------------------------------------------------------------------------
module pipeline_stall_ctrl #(
    parameter int unsigned MULDIV_CYCLES = 32,
    parameter int unsigned WDOG_WIDTH    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       if_mem_wait,
    input  logic       mem_mem_wait,
    input  logic       id_load_use,
    input  logic       ex_muldiv_start,
    input  logic       flush,
    output logic [4:0] stall,
    output logic       flush_out,
    output logic       muldiv_busy,
    output logic       muldiv_done,
    output logic       watchdog_trip
);

    // Reject out-of-range configurations at elaboration time.
    if ((MULDIV_CYCLES < 2) || (MULDIV_CYCLES > 255) || (WDOG_WIDTH < 1)) begin : g_param_check
        $error("pipeline_stall_ctrl: MULDIV_CYCLES must be 2..255 and WDOG_WIDTH >= 1");
    end

    localparam logic [7:0] MD_LOAD = 8'(MULDIV_CYCLES - 32'd1);

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    md_state_e  state_r, state_s;
    logic [7:0] cnt_r, cnt_s;
    logic       flush_hold_r, flush_hold_s;
    logic       flush_out_s;
    logic       md_stall_s;
    logic [4:0] stall_s;

    // Flush delivery: a pending or fresh flush goes out only when the data bus
    // is free; flush_hold remembers a flush that arrived during a bus wait.
    always_comb begin
        flush_out_s  = 1'b0;
        flush_hold_s = flush_hold_r;
        if (rst) begin
            flush_out_s  = 1'b0;
            flush_hold_s = 1'b0;
        end else begin
            flush_out_s = (flush | flush_hold_r) & ~mem_mem_wait;
            if (flush_out_s) begin
                flush_hold_s = 1'b0;
            end else if (flush && mem_mem_wait) begin
                flush_hold_s = 1'b1;
            end else begin
                flush_hold_s = flush_hold_r;
            end
        end
    end

    // Mul/div sequencer next-state and its EX-stall contribution. A delivered
    // flush kills the op and withdraws the stall in the same cycle.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        md_stall_s = 1'b0;
        case (state_r)
            MD_IDLE: begin
                if (ex_muldiv_start && !flush_out_s) begin
                    state_s    = MD_BUSY;
                    cnt_s      = MD_LOAD;
                    md_stall_s = 1'b1;
                end else begin
                    state_s = MD_IDLE;
                end
            end
            MD_BUSY: begin
                if (flush_out_s) begin
                    state_s = MD_IDLE;
                    cnt_s   = 8'd0;
                end else begin
                    md_stall_s = 1'b1;
                    if (cnt_r == 8'd0) begin
                        state_s = MD_DONE;
                    end else begin
                        cnt_s = cnt_r - 8'd1;
                    end
                end
            end
            MD_DONE: begin
                // The result must stay valid while MEM is frozen.
                if (flush_out_s) begin
                    state_s = MD_IDLE;
                end else if (mem_mem_wait) begin
                    state_s = MD_DONE;
                end else begin
                    state_s = MD_IDLE;
                end
            end
            default: begin
                state_s = MD_IDLE;
                cnt_s   = 8'd0;
            end
        endcase
    end

    // Stall vector: OR of per-source masks, each already monotonic, so the
    // union stays monotonic and WB never stalls. Forced quiet during reset.
    always_comb begin
        stall_s = 5'b00000;
        if (rst) begin
            stall_s = 5'b00000;
        end else begin
            stall_s = {1'b0, {4{mem_mem_wait}}}
                    | {2'b00, {3{md_stall_s}}}
                    | {3'b000, {2{id_load_use & ~flush_out_s}}}
                    | {4'b0000, if_mem_wait};
        end
    end

    // Sequencer, counter and flush-hold state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= MD_IDLE;
            cnt_r        <= 8'd0;
            flush_hold_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            flush_hold_r <= flush_hold_s;
        end
    end

    assign stall       = stall_s;
    assign flush_out   = flush_out_s;
    assign muldiv_busy = (state_r == MD_BUSY) & ~rst;
    assign muldiv_done = (state_r == MD_DONE) & ~rst;

`ifdef STALL_WATCHDOG_EN
    localparam logic [WDOG_WIDTH-1:0] WDOG_MAX = {WDOG_WIDTH{1'b1}};
    localparam logic [WDOG_WIDTH-1:0] WDOG_ONE = {{(WDOG_WIDTH-1){1'b0}}, 1'b1};

    logic [WDOG_WIDTH-1:0] wdog_cnt_r, wdog_cnt_s;
    logic                  wdog_trip_r, wdog_trip_s;

    // Watchdog: count consecutive IF-stall cycles, saturate, latch the trip.
    always_comb begin
        wdog_cnt_s  = wdog_cnt_r;
        wdog_trip_s = wdog_trip_r;
        if (!stall_s[0]) begin
            wdog_cnt_s = {WDOG_WIDTH{1'b0}};
        end else if (wdog_cnt_r == WDOG_MAX) begin
            wdog_cnt_s = WDOG_MAX;
        end else begin
            wdog_cnt_s = wdog_cnt_r + WDOG_ONE;
        end
        if (wdog_cnt_s == WDOG_MAX) begin
            wdog_trip_s = 1'b1;
        end else begin
            wdog_trip_s = wdog_trip_r;
        end
    end

    // Watchdog registers; the trip flag only clears on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt_r  <= {WDOG_WIDTH{1'b0}};
            wdog_trip_r <= 1'b0;
        end else begin
            wdog_cnt_r  <= wdog_cnt_s;
            wdog_trip_r <= wdog_trip_s;
        end
    end

    assign watchdog_trip = wdog_trip_r;
`else
    assign watchdog_trip = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
//
// Directed bench for pipeline_stall_ctrl (MULDIV_CYCLES=32, WDOG_WIDTH=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled a
// further time unit later, well clear of the next edge.
// ----------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       if_mem_wait;
    logic       mem_mem_wait;
    logic       id_load_use;
    logic       ex_muldiv_start;
    logic       flush;
    logic [4:0] stall;
    logic       flush_out;
    logic       muldiv_busy;
    logic       muldiv_done;
    logic       watchdog_trip;

    int err_cnt = 0;
    int chk_cnt = 0;

    pipeline_stall_ctrl #(
        .MULDIV_CYCLES (32),
        .WDOG_WIDTH    (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .if_mem_wait     (if_mem_wait),
        .mem_mem_wait    (mem_mem_wait),
        .id_load_use     (id_load_use),
        .ex_muldiv_start (ex_muldiv_start),
        .flush           (flush),
        .stall           (stall),
        .flush_out       (flush_out),
        .muldiv_busy     (muldiv_busy),
        .muldiv_done     (muldiv_done),
        .watchdog_trip   (watchdog_trip)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_mem_wait     = 1'b0;
        mem_mem_wait    = 1'b0;
        id_load_use     = 1'b0;
        ex_muldiv_start = 1'b0;
        flush           = 1'b0;
    endtask

    initial begin
        int n;
        int bad;

        // ---------------- reset state, inputs active ----------------
        rst             = 1'b1;
        if_mem_wait     = 1'b1;
        mem_mem_wait    = 1'b1;
        id_load_use     = 1'b1;
        ex_muldiv_start = 1'b1;
        flush           = 1'b1;
        tick();
        tick();
        check("rst_stall",  {27'd0, stall}, 32'd0);
        check("rst_flush",  {31'd0, flush_out}, 32'd0);
        check("rst_busy",   {31'd0, muldiv_busy}, 32'd0);
        check("rst_done",   {31'd0, muldiv_done}, 32'd0);
        check("rst_trip",   {31'd0, watchdog_trip}, 32'd0);
        idle_inputs();
        #1;
        rst = 1'b0;
        tick();
        check("idle_stall", {27'd0, stall}, 32'd0);
        check("idle_busy",  {31'd0, muldiv_busy}, 32'd0);

        // ---------------- priority / combining ----------------
        mem_mem_wait = 1'b1; id_load_use = 1'b1; #1;
        check("prio_mem_lu", {27'd0, stall}, 32'h0F);
        idle_inputs(); id_load_use = 1'b1; #1;
        check("prio_lu", {27'd0, stall}, 32'h03);
        idle_inputs(); if_mem_wait = 1'b1; #1;
        check("prio_ifw", {27'd0, stall}, 32'h01);
        idle_inputs(); mem_mem_wait = 1'b1; if_mem_wait = 1'b1; #1;
        check("prio_mem_ifw", {27'd0, stall}, 32'h0F);
        idle_inputs(); #1;
        check("prio_none", {27'd0, stall}, 32'h00);
        tick();

        // ---------------- watchdog ----------------
        if_mem_wait = 1'b1;
        for (int i = 1; i <= 14; i++) tick();
        check("wdog_14", {31'd0, watchdog_trip}, 32'd0);
        tick();
`ifdef STALL_WATCHDOG_EN
        check("wdog_15", {31'd0, watchdog_trip}, 32'd1);
`else
        check("wdog_15_off", {31'd0, watchdog_trip}, 32'd0);
`endif
        if_mem_wait = 1'b0;
        tick();
        tick();
`ifdef STALL_WATCHDOG_EN
        check("wdog_sticky", {31'd0, watchdog_trip}, 32'd1);
`else
        check("wdog_sticky_off", {31'd0, watchdog_trip}, 32'd0);
`endif

        // ---------------- mul/div full op ----------------
        ex_muldiv_start = 1'b1; #1;
        check("md_start_stall", {27'd0, stall}, 32'h07);
        check("md_start_busy", {31'd0, muldiv_busy}, 32'd0);
        tick();
        ex_muldiv_start = 1'b0;
        bad = 0;
        for (int i = 1; i <= 32; i++) begin
            if (stall !== 5'b00111 || muldiv_busy !== 1'b1 || muldiv_done !== 1'b0) bad++;
            if (i != 32) tick();
        end
        check("md_busy_32", bad, 32'd0);
        tick();
        check("md_done", {31'd0, muldiv_done}, 32'd1);
        check("md_done_stall", {27'd0, stall}, 32'h00);
        tick();
        check("md_done_1cyc", {31'd0, muldiv_done}, 32'd0);
        check("md_idle_busy", {31'd0, muldiv_busy}, 32'd0);

        // ---------------- DONE held by data-bus wait ----------------
        ex_muldiv_start = 1'b1;
        tick();
        ex_muldiv_start = 1'b0;
        for (int i = 1; i <= 32; i++) tick();
        mem_mem_wait = 1'b1; #1;
        check("md_done_w", {31'd0, muldiv_done}, 32'd1);
        check("md_done_w_stall", {27'd0, stall}, 32'h0F);
        tick();
        check("md_done_hold", {31'd0, muldiv_done}, 32'd1);
        mem_mem_wait = 1'b0;
        tick();
        check("md_done_rel", {31'd0, muldiv_done}, 32'd0);

        // ---------------- flush during BUSY ----------------
        ex_muldiv_start = 1'b1;
        tick();
        ex_muldiv_start = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        flush = 1'b1; id_load_use = 1'b1; #1;
        check("fb_flush_out", {31'd0, flush_out}, 32'd1);
        check("fb_stall", {27'd0, stall}, 32'h00);
        tick();
        idle_inputs(); #1;
        check("fb_idle_busy", {31'd0, muldiv_busy}, 32'd0);
        check("fb_flush_once", {31'd0, flush_out}, 32'd0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (muldiv_done) n++;
            tick();
        end
        check("fb_no_done", n, 32'd0);

        // ---------------- flush during data-bus wait ----------------
        mem_mem_wait = 1'b1; flush = 1'b1; #1;
        check("fw_held", {31'd0, flush_out}, 32'd0);
        check("fw_stall", {27'd0, stall}, 32'h0F);
        tick();
        flush = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (flush_out) n++;
            tick();
        end
        check("fw_quiet", n, 32'd0);
        mem_mem_wait = 1'b0; #1;
        check("fw_deliver", {31'd0, flush_out}, 32'd1);
        tick();
        check("fw_once", {31'd0, flush_out}, 32'd0);

        // ---------------- reset mid-BUSY ----------------
        ex_muldiv_start = 1'b1;
        tick();
        ex_muldiv_start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        check("rb_busy_before", {31'd0, muldiv_busy}, 32'd1);
        rst = 1'b1; #1;
        check("rb_stall", {27'd0, stall}, 32'h00);
        check("rb_busy", {31'd0, muldiv_busy}, 32'd0);
        check("rb_trip", {31'd0, watchdog_trip}, 32'd0);
        tick();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (muldiv_done || muldiv_busy) n++;
        end
        check("rb_no_done", n, 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL have parameter MULDIV_CYCLES, default 32, the number of BUSY cycles of a mul/div op (range 2..255).
REQ-002 SHALL have parameter WDOG_WIDTH, default 16, the watchdog counter width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 if_mem_wait  input  1  instruction bus not ready.
REQ-006 mem_mem_wait  input  1  data bus not ready.
REQ-007 id_load_use  input  1  load-use hazard detected in ID.
REQ-008 ex_muldiv_start  input  1  EX holds a mul/div starting this cycle.
REQ-009 flush  input  1  exception/eret flush request (level, one cycle typical).
REQ-010 stall  output  5  per-stage stall, bit0=IF, 1=ID, 2=EX, 3=MEM, 4=WB; drives the stall inputs of the pipeline deliver registers.
REQ-011 flush_out  output  1  flush delivered to the pipeline.
REQ-012 muldiv_busy  output  1  mul/div FSM in BUSY.
REQ-013 muldiv_done  output  1  mul/div FSM in DONE (result valid).
REQ-014 watchdog_trip  output  1  sticky stall-hang flag.

Function
REQ-015 stall SHALL be monotonic: if bit k=1, all bits below k SHALL be 1; stall[4] SHALL always be 0.
REQ-016 mem_mem_wait=1 SHALL set stall[3:0]=4'b1111 combinationally in the same cycle.
REQ-017 Mul/div stall (IDLE&ex_muldiv_start&!flush_out, or state BUSY) SHALL set stall[2:0]=3'b111.
REQ-018 id_load_use=1 SHALL set stall[1:0]=2'b11 unless flush_out=1.
REQ-019 if_mem_wait=1 SHALL set stall[0]=1.
REQ-020 stall SHALL be the bitwise OR of the REQ-016..019 contributions.
REQ-021 Mul/div FSM states SHALL be IDLE, BUSY, DONE; IDLE->BUSY when ex_muldiv_start=1 and flush_out=0, loading an 8-bit counter with MULDIV_CYCLES-1.
REQ-022 In BUSY, the counter SHALL decrement every cycle; at counter==0, the FSM SHALL go BUSY->DONE; EX stall therefore lasts MULDIV_CYCLES+1 cycles including the start cycle.
REQ-023 DONE SHALL last one cycle, then go to IDLE; if mem_mem_wait=1 in DONE, the FSM SHALL remain in DONE until it clears.
REQ-024 flush_out=1 in BUSY or DONE SHALL force IDLE next cycle; the mul/div stall contribution SHALL drop in the same cycle.
REQ-025 flush_out SHALL equal (flush|flush_hold)&!mem_mem_wait.
REQ-026 flush_hold SHALL set when flush=1 and mem_mem_wait=1, and SHALL clear on the first cycle flush_out=1.
REQ-027 A flush arriving during a bus wait SHALL be delivered exactly once, in the first cycle mem_mem_wait=0.

Reset
REQ-028 On rst=1, the FSM SHALL go to IDLE, and the counter, flush_hold, the watchdog counter and watchdog_trip SHALL clear to 0, immediately and without clk.
REQ-029 During reset, stall, muldiv_busy and muldiv_done SHALL be 0 and flush_out SHALL be 0, regardless of inputs.
REQ-030 Reset asserted mid-BUSY SHALL abort the op; no muldiv_done SHALL follow.

Configuration
REQ-031 Macro STALL_WATCHDOG_EN defined: a WDOG_WIDTH-bit counter SHALL increment each cycle stall[0]=1, clear when stall[0]=0, and saturate at all-ones; on reaching all-ones, watchdog_trip SHALL set and stay set until rst.
REQ-032 Macro STALL_WATCHDOG_EN undefined: there SHALL be no counter logic, and watchdog_trip SHALL be constant 0.

Verification
REQ-033 Reset: rst pulse mid-BUSY (MULDIV_CYCLES=32, cycle 10) -> stall=0, muldiv_busy=0 immediately, with no muldiv_done afterwards.
REQ-034 Mul/div: start pulse with no other requests -> stall=5'b00111 for 33 consecutive cycles, then muldiv_done=1 for exactly 1 cycle with stall=0.
REQ-035 Priority: mem_mem_wait=1 and id_load_use=1 together -> stall=5'b01111; load_use alone -> 5'b00011; if_mem_wait alone -> 5'b00001.
REQ-036 Flush during wait: flush pulse while mem_mem_wait=1 for 5 cycles -> flush_out=0 for those cycles, then flush_out=1 for exactly 1 cycle when the wait drops.
REQ-037 Flush during BUSY: flush at BUSY cycle 5 -> stall[2]=0 in that cycle, IDLE next, with no muldiv_done.
REQ-038 Watchdog (macro on, WDOG_WIDTH=4): if_mem_wait held for 15 cycles -> watchdog_trip=1 and stays 1 after the wait drops; with the macro off, it stays 0.
